// File: rtl/hazard_pkg.sv
// Shared types for the pipeline hazard controller: FSM state encoding and register-index type.
package hazard_pkg;

    localparam int REGW_DEF = 5;

    typedef logic [REGW_DEF-1:0] regbits_t;

    typedef enum logic {
        RUN    = 1'b0,
        DSTALL = 1'b1
    } hz_state_t;

endpackage

// File: rtl/hz_sat_counter.sv
// Up-counter that saturates at MAX; synchronous clear has priority over increment.
module hz_sat_counter #(
    parameter int          W   = 16,
    parameter int unsigned MAX = 65535
) (
    input  logic         CLK,
    input  logic         nRST,
    input  logic         inc,
    input  logic         clr,
    output logic [W-1:0] cnt,
    output logic         at_max
);

    logic [W-1:0] r_cnt;

    assign cnt    = r_cnt;
    assign at_max = (r_cnt == W'(MAX));

    // Counter register: clear, saturating increment, or hold.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_cnt <= '0;
        end else if (clr) begin
            r_cnt <= '0;
        end else if (inc && !at_max) begin
            r_cnt <= r_cnt + W'(1);
        end else begin
            r_cnt <= r_cnt;
        end
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Hazard/stall controller: D-miss freeze with held redirects, load-use interlock,
// I-miss bubbles, redirect squash, saturating stall counter and sticky stall watchdog.
module pipeline_hazard_ctrl #(
    parameter int NLATCH    = 4,
    parameter int REDIR_LAT = 2,
    parameter int MEM_LAT   = 2,
    parameter int REGW      = 5,
    parameter int CNTW      = 16,
    parameter int TIMEOUT   = 1024
) (
    input  logic              CLK,
    input  logic              nRST,
    input  logic              ihit,
    input  logic              dhit,
    input  logic              mem_dREN,
    input  logic              mem_dWEN,
    input  logic              ex_memread,
    input  logic [REGW-1:0]   ex_rd,
    input  logic [REGW-1:0]   id_rs,
    input  logic [REGW-1:0]   id_rt,
    input  logic              redirect,
    output logic              pc_wen,
    output logic [NLATCH-1:0] latch_wen,
    output logic [NLATCH-1:0] latch_flush,
    output logic              redir_take,
    output logic [CNTW-1:0]   stall_cnt,
    output logic              hz_timeout
);

    import hazard_pkg::*;

    localparam int WDW = $clog2(TIMEOUT + 1);
    localparam logic [NLATCH-1:0] ALL_LAT     = {NLATCH{1'b1}};
    localparam logic [NLATCH-1:0] SQUASH_MASK = NLATCH'((64'd1 << REDIR_LAT) - 64'd1);
    localparam logic [NLATCH-1:0] IF_LAT      = NLATCH'(32'd1);
    localparam logic [NLATCH-1:0] BUBBLE_LAT  = NLATCH'(32'd2);

    // The memory-stage latch must exist and the squash window must fit in the pipe.
    if (MEM_LAT >= NLATCH || REDIR_LAT > NLATCH || NLATCH < 2) begin : g_bad_params
        $error("pipeline_hazard_ctrl: inconsistent latch parameters");
    end

    hz_state_t         r_state;
    hz_state_t         w_state_nxt;
    logic              r_pend;
    logic              w_pend_nxt;
    logic              r_timeout;
    logic              w_dmiss;
    logic              w_luse;
    logic              w_pc_wen;
    logic              w_redir_take;
    logic [NLATCH-1:0] w_wen;
    logic [NLATCH-1:0] w_flush;
    logic              w_stall;
    logic              w_stall_sat;
    logic [WDW-1:0]    w_wd_cnt;
    logic              w_wd_at_max;
    logic              w_unused;

    assign w_dmiss = (mem_dREN | mem_dWEN) & ~dhit;
    assign w_luse  = ex_memread & (ex_rd != '0) & ((ex_rd == id_rs) | (ex_rd == id_rt));
    assign w_stall = ~w_pc_wen;

    // Next-state and priority decode into PC and latch controls.
    always_comb begin
        w_state_nxt  = r_state;
        w_pend_nxt   = r_pend;
        w_pc_wen     = 1'b1;
        w_redir_take = 1'b0;
        w_wen        = ALL_LAT;
        w_flush      = '0;
        case (r_state)
            RUN: begin
                if (w_dmiss) begin
                    w_pc_wen    = 1'b0;
                    w_wen       = '0;
                    w_state_nxt = DSTALL;
                    w_pend_nxt  = r_pend | redirect;
                end else if (redirect) begin
                    w_redir_take = 1'b1;
                    w_flush      = SQUASH_MASK;
                end else if (w_luse) begin
                    w_pc_wen = 1'b0;
                    w_wen    = ALL_LAT & ~IF_LAT;
                    w_flush  = BUBBLE_LAT;
                end else if (!ihit) begin
                    w_pc_wen = 1'b0;
                    w_flush  = IF_LAT;
                end else begin
                    w_pc_wen = 1'b1;
                end
            end
            DSTALL: begin
                if (!dhit) begin
                    w_pc_wen   = 1'b0;
                    w_wen      = '0;
                    w_pend_nxt = r_pend | redirect;
                end else begin
                    // Data returns: everything advances; a held redirect squashes now.
                    w_state_nxt = RUN;
                    w_pend_nxt  = 1'b0;
                    if (r_pend | redirect) begin
                        w_redir_take = 1'b1;
                        w_flush      = SQUASH_MASK;
                    end else begin
                        w_flush = '0;
                    end
                end
            end
            default: begin
                w_pc_wen    = 1'b0;
                w_wen       = '0;
                w_state_nxt = RUN;
                w_pend_nxt  = 1'b0;
            end
        endcase
    end

    // Outputs are forced to a safe bubble-everything pattern while reset is held.
    always_comb begin
        if (!nRST) begin
            pc_wen      = 1'b0;
            latch_wen   = '0;
            latch_flush = ALL_LAT;
            redir_take  = 1'b0;
        end else begin
            pc_wen      = w_pc_wen;
            latch_wen   = w_wen;
            latch_flush = w_flush;
            redir_take  = w_redir_take;
        end
    end

    // FSM state, held-redirect flag and sticky watchdog flag.
    always_ff @(posedge CLK or negedge nRST) begin
        if (!nRST) begin
            r_state   <= RUN;
            r_pend    <= 1'b0;
            r_timeout <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_pend    <= w_pend_nxt;
            r_timeout <= r_timeout | w_wd_at_max;
        end
    end

    hz_sat_counter #(
        .W   (CNTW),
        .MAX ((1 << CNTW) - 1)
    ) u_stall_cnt (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (w_stall),
        .clr    (1'b0),
        .cnt    (stall_cnt),
        .at_max (w_stall_sat)
    );

    // Watchdog run length restarts whenever the PC advances.
    hz_sat_counter #(
        .W   (WDW),
        .MAX (TIMEOUT)
    ) u_watchdog (
        .CLK    (CLK),
        .nRST   (nRST),
        .inc    (w_stall),
        .clr    (~w_stall),
        .cnt    (w_wd_cnt),
        .at_max (w_wd_at_max)
    );

    assign hz_timeout = r_timeout | w_wd_at_max;
    assign w_unused   = ^{w_stall_sat, w_wd_cnt};

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// Directed self-checking bench for pipeline_hazard_ctrl (small counter/timeout parameters).
module tb_pipeline_hazard_ctrl;

    import hazard_pkg::*;

    logic       CLK;
    logic       nRST;
    logic       ihit, dhit, mem_dREN, mem_dWEN, ex_memread, redirect;
    regbits_t   ex_rd, id_rs, id_rt;
    logic       pc_wen, redir_take, hz_timeout;
    logic [3:0] latch_wen, latch_flush, stall_cnt;
    logic [9:0] ctl;

    int n_vec = 0;
    int n_err = 0;

    pipeline_hazard_ctrl #(
        .NLATCH(4), .REDIR_LAT(2), .MEM_LAT(2), .REGW(5), .CNTW(4), .TIMEOUT(20)
    ) dut (
        .CLK(CLK), .nRST(nRST), .ihit(ihit), .dhit(dhit),
        .mem_dREN(mem_dREN), .mem_dWEN(mem_dWEN), .ex_memread(ex_memread),
        .ex_rd(ex_rd), .id_rs(id_rs), .id_rt(id_rt), .redirect(redirect),
        .pc_wen(pc_wen), .latch_wen(latch_wen), .latch_flush(latch_flush),
        .redir_take(redir_take), .stall_cnt(stall_cnt), .hz_timeout(hz_timeout)
    );

    // {pc_wen, redir_take, latch_wen, latch_flush}
    assign ctl = {pc_wen, redir_take, latch_wen, latch_flush};

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    task automatic idle();
        ihit = 1'b1; dhit = 1'b0; mem_dREN = 1'b0; mem_dWEN = 1'b0;
        ex_memread = 1'b0; ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0; redirect = 1'b0;
    endtask

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic do_reset();
        idle();
        nRST = 1'b0;
        tick();
        tick();
        nRST = 1'b1;
    endtask

    task automatic test_reset();
        nRST = 1'b0;
        ihit = 1'b0; dhit = 1'b1; mem_dREN = 1'b1; mem_dWEN = 1'b1; redirect = 1'b1;
        ex_memread = 1'b1; ex_rd = 5'd3; id_rs = 5'd3; id_rt = 5'd7;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_0000_1111) begin
            n_err++; $display("FAIL reset_ctl: got %b want %b", ctl, 10'b0_0_0000_1111);
        end
        tick();
        n_vec++;
        if ({stall_cnt, hz_timeout} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL reset_cnt: got cnt=%0d to=%b want cnt=0 to=0", stall_cnt, hz_timeout);
        end
        n_vec++;
        if (ctl !== 10'b0_0_0000_1111) begin
            n_err++; $display("FAIL reset_ctl_edge: got %b want %b", ctl, 10'b0_0_0000_1111);
        end
        idle();
        nRST = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_0_1111_0000) begin
            n_err++; $display("FAIL reset_release: got %b want %b", ctl, 10'b1_0_1111_0000);
        end
        tick();
    endtask

    task automatic test_load_use();
        do_reset();
        ex_memread = 1'b1; ex_rd = 5'd8; id_rs = 5'd3; id_rt = 5'd8;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_1110_0010) begin
            n_err++; $display("FAIL luse_rt: got %b want %b", ctl, 10'b0_0_1110_0010);
        end
        tick();
        ex_rd = 5'd0; id_rs = 5'd0; id_rt = 5'd0;
        #1;
        n_vec++;
        if (ctl !== 10'b1_0_1111_0000) begin
            n_err++; $display("FAIL luse_r0: got %b want %b", ctl, 10'b1_0_1111_0000);
        end
        tick();
        ex_rd = 5'd9; id_rs = 5'd9; id_rt = 5'd4;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_1110_0010) begin
            n_err++; $display("FAIL luse_rs: got %b want %b", ctl, 10'b0_0_1110_0010);
        end
        tick();
        id_rs = 5'd4; id_rt = 5'd5;
        #1;
        n_vec++;
        if (ctl !== 10'b1_0_1111_0000) begin
            n_err++; $display("FAIL luse_nomatch: got %b want %b", ctl, 10'b1_0_1111_0000);
        end
        tick();
        ex_memread = 1'b0; ex_rd = 5'd8; id_rt = 5'd8;
        #1;
        n_vec++;
        if (ctl !== 10'b1_0_1111_0000) begin
            n_err++; $display("FAIL luse_notload: got %b want %b", ctl, 10'b1_0_1111_0000);
        end
        tick();
        n_vec++;
        if (stall_cnt !== 4'd2) begin
            n_err++; $display("FAIL luse_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_dmiss();
        do_reset();
        mem_dREN = 1'b1;
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({ctl, stall_cnt} !== {10'b0_0_0000_0000, 4'(i)}) begin
                n_err++; $display("FAIL dmiss_freeze%0d: got ctl=%b cnt=%0d want ctl=0000000000 cnt=%0d", i, ctl, stall_cnt, i);
            end
            tick();
        end
        dhit = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_0_1111_0000) begin
            n_err++; $display("FAIL dmiss_dhit: got %b want %b", ctl, 10'b1_0_1111_0000);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if ({ctl, stall_cnt} !== {10'b1_0_1111_0000, 4'd3}) begin
            n_err++; $display("FAIL dmiss_after: got ctl=%b cnt=%0d want ctl=1011110000 cnt=3", ctl, stall_cnt);
        end
        tick();
        mem_dWEN = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_0000_0000) begin
            n_err++; $display("FAIL dmiss_write: got %b want %b", ctl, 10'b0_0_0000_0000);
        end
        tick();
        dhit = 1'b1;
        tick();
        idle();
        n_vec++;
        if (stall_cnt !== 4'd4) begin
            n_err++; $display("FAIL dmiss_cnt: got %0d want 4", stall_cnt);
        end
    endtask

    task automatic test_redirect_in_miss();
        do_reset();
        mem_dREN = 1'b1;
        tick();
        redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_0000_0000) begin
            n_err++; $display("FAIL rim_hold: got %b want %b", ctl, 10'b0_0_0000_0000);
        end
        tick();
        redirect = 1'b0;
        tick();
        dhit = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_1_1111_0011) begin
            n_err++; $display("FAIL rim_take: got %b want %b", ctl, 10'b1_1_1111_0011);
        end
        tick();
        idle();
        #1;
        n_vec++;
        if ({ctl, stall_cnt} !== {10'b1_0_1111_0000, 4'd3}) begin
            n_err++; $display("FAIL rim_cleared: got ctl=%b cnt=%0d want ctl=1011110000 cnt=3", ctl, stall_cnt);
        end
        tick();
    endtask

    task automatic test_imiss_redirect();
        do_reset();
        ihit = 1'b0; redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_1_1111_0011) begin
            n_err++; $display("FAIL imiss_redir: got %b want %b", ctl, 10'b1_1_1111_0011);
        end
        tick();
        redirect = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_1111_0001) begin
            n_err++; $display("FAIL imiss_only: got %b want %b", ctl, 10'b0_0_1111_0001);
        end
        tick();
        ihit = 1'b1; ex_memread = 1'b1; ex_rd = 5'd5; id_rs = 5'd5; redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_1_1111_0011) begin
            n_err++; $display("FAIL redir_over_luse: got %b want %b", ctl, 10'b1_1_1111_0011);
        end
        tick();
        redirect = 1'b0; ihit = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_1110_0010) begin
            n_err++; $display("FAIL luse_over_imiss: got %b want %b", ctl, 10'b0_0_1110_0010);
        end
        tick();
        idle();
        n_vec++;
        if (stall_cnt !== 4'd2) begin
            n_err++; $display("FAIL imiss_cnt: got %0d want 2", stall_cnt);
        end
    endtask

    task automatic test_back_to_back();
        do_reset();
        mem_dREN = 1'b1; redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_0000_0000) begin
            n_err++; $display("FAIL b2b_miss_redir: got %b want %b", ctl, 10'b0_0_0000_0000);
        end
        tick();
        redirect = 1'b0; dhit = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_1_1111_0011) begin
            n_err++; $display("FAIL b2b_pend_take: got %b want %b", ctl, 10'b1_1_1111_0011);
        end
        tick();
        redirect = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_1_1111_0011) begin
            n_err++; $display("FAIL b2b_hit_redir: got %b want %b", ctl, 10'b1_1_1111_0011);
        end
        tick();
        redirect = 1'b0; dhit = 1'b0;
        #1;
        n_vec++;
        if (ctl !== 10'b0_0_0000_0000) begin
            n_err++; $display("FAIL b2b_new_miss: got %b want %b", ctl, 10'b0_0_0000_0000);
        end
        tick();
        dhit = 1'b1;
        #1;
        n_vec++;
        if (ctl !== 10'b1_0_1111_0000) begin
            n_err++; $display("FAIL b2b_no_stale_pend: got %b want %b", ctl, 10'b1_0_1111_0000);
        end
        tick();
        idle();
    endtask

    task automatic test_watchdog();
        logic [3:0] exp_cnt;
        logic       exp_to;
        do_reset();
        mem_dREN = 1'b1;
        for (int i = 0; i < 25; i++) begin
            exp_cnt = (i > 15) ? 4'd15 : 4'(i);
            exp_to  = (i >= 20);
            #1;
            n_vec++;
            if ({stall_cnt, hz_timeout} !== {exp_cnt, exp_to}) begin
                n_err++; $display("FAIL wdog_step%0d: got cnt=%0d to=%b want cnt=%0d to=%b", i, stall_cnt, hz_timeout, exp_cnt, exp_to);
            end
            tick();
        end
        dhit = 1'b1;
        #1;
        n_vec++;
        if ({ctl, stall_cnt, hz_timeout} !== {10'b1_0_1111_0000, 4'd15, 1'b1}) begin
            n_err++; $display("FAIL wdog_dhit: got ctl=%b cnt=%0d to=%b want ctl=1011110000 cnt=15 to=1", ctl, stall_cnt, hz_timeout);
        end
        tick();
        idle();
        for (int i = 0; i < 3; i++) begin
            #1;
            n_vec++;
            if ({stall_cnt, hz_timeout} !== {4'd15, 1'b1}) begin
                n_err++; $display("FAIL wdog_sticky%0d: got cnt=%0d to=%b want cnt=15 to=1", i, stall_cnt, hz_timeout);
            end
            tick();
        end
        nRST = 1'b0;
        #1;
        n_vec++;
        if ({stall_cnt, hz_timeout} !== {4'd0, 1'b0}) begin
            n_err++; $display("FAIL wdog_reset: got cnt=%0d to=%b want cnt=0 to=0", stall_cnt, hz_timeout);
        end
        nRST = 1'b1;
        tick();
    endtask

    initial begin
        idle();
        nRST = 1'b0;
        test_reset();
        test_load_use();
        test_dmiss();
        test_redirect_in_miss();
        test_imiss_redirect();
        test_back_to_back();
        test_watchdog();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
